// File: rtl/seq_detector.sv
// Serial pattern detector: compares the last LEN accepted bits against a
// runtime-loadable pattern, with overlap/non-overlap modes and a saturating match counter.
module seq_detector #(
    parameter int              LEN          = 4,
    parameter int              OVERLAP      = 1,
    parameter int              CNT_W        = 8,
    parameter logic [LEN-1:0]  PATTERN_INIT = LEN'(4'b1011)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_value,
    input  logic             pattern_load,
    input  logic [LEN-1:0]   pattern_in,
    input  logic             count_clear,
    output logic             match,
    output logic             armed,
    output logic [CNT_W-1:0] match_count
);

    localparam int FW = $clog2(LEN + 1);
    localparam logic [FW-1:0]    FULL    = FW'(LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // FILL: window still collecting bits; DETECT: window holds LEN valid bits.
    // armed is the externally visible state of this FSM.
    typedef enum logic {FILL, DETECT} state_t;

    state_t           state, state_d;
    logic [LEN-1:0]   pattern, pattern_d;
    logic [LEN-1:0]   history, history_d;
    logic [FW-1:0]    fill, fill_d;
    logic             match_d;
    logic [CNT_W-1:0] count_d;

    logic             accept;
    logic             hit;
    logic [LEN-1:0]   shifted;
    logic [FW-1:0]    fill_inc;

    // Input strobe semantics: a bit is taken on a rising edge only when en=1;
    // there is no back-pressure. pattern_load on the same edge discards the bit.
    always_comb begin
        accept    = en & ~pattern_load;
        shifted   = {history[LEN-2:0], in_value};
        fill_inc  = (fill == FULL) ? FULL : fill + FW'(1);
        hit       = accept && (shifted == pattern) && (fill_inc == FULL);

        pattern_d = pattern;
        history_d = history;
        fill_d    = fill;
        state_d   = state;
        match_d   = 1'b0;
        count_d   = match_count;

        if (pattern_load) begin
            pattern_d = pattern_in;
            history_d = '0;
            fill_d    = '0;
            state_d   = FILL;
        end else if (accept) begin
            match_d = hit;
            if (hit && (OVERLAP == 0)) begin
                history_d = '0;
                fill_d    = '0;
                state_d   = FILL;
            end else begin
                history_d = shifted;
                fill_d    = fill_inc;
                state_d   = (fill_inc == FULL) ? DETECT : FILL;
            end
        end

        // Clear wins over a same-edge increment.
        if (count_clear) begin
            count_d = '0;
        end else if (hit && (match_count != CNT_MAX)) begin
            count_d = match_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            pattern     <= PATTERN_INIT;
            history     <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            state       <= state_d;
            pattern     <= pattern_d;
            history     <= history_d;
            fill        <= fill_d;
            match       <= match_d;
            match_count <= count_d;
        end
    end

    assign armed = (state == DETECT);

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: three configurations driven in parallel and checked
// every cycle against an arithmetic model of the accepted-bit window.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       in_value = 1'b0;
    logic       pattern_load = 1'b0;
    logic [3:0] pattern_in = 4'b0000;
    logic       count_clear = 1'b0;

    logic       m_ov, a_ov, m_no, a_no, m_c2, a_c2;
    logic [7:0] c_ov, c_no;
    logic [1:0] c_c2;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit chk_on   = 1'b0;

    // model state per instance: 0 = overlap, 1 = non-overlap, 2 = 2-bit counter
    int ov_cfg [3] = '{1, 0, 1};
    int cmax   [3] = '{255, 255, 3};
    int pat    [3];
    int n_acc  [3];
    int win    [3];
    int e_match[3];
    int e_cnt  [3];

    always #5 clk = ~clk;

    seq_detector #(.LEN(4), .OVERLAP(1), .CNT_W(8), .PATTERN_INIT(4'b1011)) u_ov (
        .clk(clk), .reset(reset), .en(en), .in_value(in_value),
        .pattern_load(pattern_load), .pattern_in(pattern_in), .count_clear(count_clear),
        .match(m_ov), .armed(a_ov), .match_count(c_ov));

    seq_detector #(.LEN(4), .OVERLAP(0), .CNT_W(8), .PATTERN_INIT(4'b1011)) u_no (
        .clk(clk), .reset(reset), .en(en), .in_value(in_value),
        .pattern_load(pattern_load), .pattern_in(pattern_in), .count_clear(count_clear),
        .match(m_no), .armed(a_no), .match_count(c_no));

    seq_detector #(.LEN(4), .OVERLAP(1), .CNT_W(2), .PATTERN_INIT(4'b1011)) u_c2 (
        .clk(clk), .reset(reset), .en(en), .in_value(in_value),
        .pattern_load(pattern_load), .pattern_in(pattern_in), .count_clear(count_clear),
        .match(m_c2), .armed(a_c2), .match_count(c_c2));

    // Reference: the window is the last 4 accepted bits as an integer; a match
    // needs at least 4 bits since the last restart and the window equal to the pattern.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                pat[i] = 11; n_acc[i] = 0; win[i] = 0; e_match[i] = 0; e_cnt[i] = 0;
            end else begin
                int hit;
                hit = 0;
                if (pattern_load) begin
                    pat[i] = int'(pattern_in); n_acc[i] = 0; win[i] = 0;
                end else if (en) begin
                    win[i] = (win[i] * 2 + int'(in_value)) % 16;
                    if (n_acc[i] < 4) n_acc[i] = n_acc[i] + 1;
                    hit = (n_acc[i] == 4 && win[i] == pat[i]) ? 1 : 0;
                    if (hit == 1 && ov_cfg[i] == 0) begin
                        n_acc[i] = 0; win[i] = 0;
                    end
                end
                e_match[i] = hit;
                if (count_clear) e_cnt[i] = 0;
                else if (hit == 1 && e_cnt[i] < cmax[i]) e_cnt[i] = e_cnt[i] + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("ov.match", int'(m_ov), e_match[0]);
            check("ov.armed", int'(a_ov), (n_acc[0] == 4) ? 1 : 0);
            check("ov.count", int'(c_ov), e_cnt[0]);
            check("no.match", int'(m_no), e_match[1]);
            check("no.armed", int'(a_no), (n_acc[1] == 4) ? 1 : 0);
            check("no.count", int'(c_no), e_cnt[1]);
            check("c2.match", int'(m_c2), e_match[2]);
            check("c2.armed", int'(a_c2), (n_acc[2] == 4) ? 1 : 0);
            check("c2.count", int'(c_c2), e_cnt[2]);
        end
    end

    task automatic step(input logic e, input logic b, input logic ld = 1'b0,
                        input logic [3:0] p = 4'b0000, input logic clr = 1'b0);
        @(negedge clk); #1;
        en = e; in_value = b; pattern_load = ld; pattern_in = p; count_clear = clr;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b1; en = 1'b0; pattern_load = 1'b0; count_clear = 1'b0;
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0] s1;
        s1 = 7'b1011011;

        #1 reset = 1'b1;
        #10;
        check("reset.match", int'(m_ov), 0);
        check("reset.armed", int'(a_ov), 0);
        check("reset.count", int'(c_ov), 0);
        reset = 1'b0;
        chk_on = 1'b1;

        // Overlap / non-overlap on 1,0,1,1,0,1,1 then one more 0
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, s1[i]);
            if (i == 3) begin
                check("lit.ov.match_bit4", int'(m_ov), 1);
                check("lit.no.match_bit4", int'(m_no), 1);
                check("lit.ov.armed_bit4", int'(a_ov), 1);
                check("lit.no.armed_bit4", int'(a_no), 0);
            end
        end
        check("lit.ov.match_bit7", int'(m_ov), 1);
        check("lit.no.match_bit7", int'(m_no), 0);
        check("lit.ov.count", int'(c_ov), 2);
        check("lit.no.count", int'(c_no), 1);
        step(1'b1, 1'b0);
        check("lit.no.armed_bit8", int'(a_no), 1);

        // Gapped enable: same stream, 3 idle cycles between bits 2 and 3
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, s1[i]);
            if (i == 5) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b1);
                    check("lit.gap.match", int'(m_ov), 0);
                end
            end
        end
        check("lit.gap.count", int'(c_ov), 2);

        // Pattern load mid-stream; simultaneous bit discarded
        do_reset();
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'b0110);
        check("lit.load.armed", int'(a_ov), 0);
        step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
        check("lit.load.nomatch", int'(m_ov), 0);
        step(1'b1, 1'b0);
        check("lit.load.match", int'(m_ov), 1);
        check("lit.load.count", int'(c_ov), 1);

        // Counter saturation and clear-vs-increment
        do_reset();
        step(1'b0, 1'b0, 1'b1, 4'b1111);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        check("lit.c2.sat", int'(c_c2), 3);
        check("lit.ov.five", int'(c_ov), 5);
        step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        check("lit.clr.count", int'(c_c2), 0);
        check("lit.clr.match", int'(m_c2), 1);

        // Randomised phase
        for (int i = 0; i < 2000; i++) begin
            logic ld, clr, e, b;
            logic [3:0] p;
            e   = ($urandom_range(0, 9) < 7);
            b   = 1'($urandom_range(0, 1));
            ld  = ($urandom_range(0, 99) < 2);
            clr = ($urandom_range(0, 99) < 3);
            p   = 4'($urandom_range(0, 15));
            step(e, b, ld, p, clr);
        end

        // Async reset between edges while armed and matching
        step(1'b0, 1'b0, 1'b1, 4'b1111);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        check("lit.pre.match", int'(m_ov), 1);
        check("lit.pre.armed", int'(a_ov), 1);
        #2 reset = 1'b1;
        #1;
        check("lit.async.match", int'(m_ov), 0);
        check("lit.async.armed", int'(a_ov), 0);
        check("lit.async.count", int'(c_ov), 0);
        @(negedge clk); #1;
        reset = 1'b0;
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
        check("lit.post.pattern", int'(m_ov), 1);
        step(1'b0, 1'b0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
